// File: rtl/top_level.sv
`timescale 1ns/1ps
// top_level
// Board wrapper for the date converter. It holds a day-of-year count N
// (01..99), which advances on a KEY[1] press or on a divider tick while SW[9]
// is set. N appears on HEX5/HEX4. The calendar month and day-of-month appear
// on HEX2 and HEX1/HEX0, and HEX3 stays blank.
//
// Ports
//   MAX10_CLK1_50  system clock; all state updates on its rising edge
//   KEY[0]         asynchronous active-low reset
//   KEY[1]         advance button, active-low, asynchronous to the clock
//   SW[9]          run: auto-advance N on each divider tick
//   SW[8]          leap year: February has 29 days
//   HEX5..HEX0     seven-segment digits, active-low, bit 7 = DP (off)
//   LEDR[0]        copy of SW[8]
//   LEDR[1]        run heartbeat, toggles on each tick while running
module top_level #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       MAX10_CLK1_50,
    input  logic [1:0] KEY,
    input  logic [9:8] SW,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5,
    output logic [1:0] LEDR
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic             clk;
    logic             rst_n;
    logic             key_s1;
    logic             key_s2;
    logic             key_q;
    logic             press;
    logic             tick;
    logic             adv;
    logic [DIV_W-1:0] div_cnt;
    logic             hb;
    logic [3:0]       n_tens;
    logic [3:0]       n_ones;
    logic [6:0]       n_bin;
    logic [6:0]       leap7;
    logic [6:0]       feb_end;
    logic [6:0]       mar_end;
    logic [3:0]       month;
    logic [6:0]       day;
    logic [3:0]       day_tens;
    logic [3:0]       day_ones;

    assign clk   = MAX10_CLK1_50;
    assign rst_n = KEY[0];

    // Active-low segment pattern for one decimal digit; DP is always off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // The edge register sits behind the synchronizer, so a press reaches N on
    // the third rising edge after KEY[1] falls. Reset loads the released
    // level, so a button already held at release is seen as a new press.
    assign press = key_q & ~key_s2;
    assign tick  = (div_cnt == DIV_MAX);
    // A press and a tick in the same cycle merge into one increment.
    assign adv   = press | (tick & SW[9]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_q   <= 1'b1;
            div_cnt <= '0;
            hb      <= 1'b0;
            n_tens  <= 4'd0;
            n_ones  <= 4'd1;
        end else begin
            key_s1 <= KEY[1];
            key_s2 <= key_s1;
            key_q  <= key_s2;

            // The divider runs whether or not the run switch is set.
            if (tick) div_cnt <= '0;
            else      div_cnt <= div_cnt + 1'b1;

            if (tick && SW[9]) hb <= ~hb;

            // N is kept as BCD. 99 wraps to 01, so 00 never appears.
            if (adv) begin
                if (n_tens == 4'd9 && n_ones == 4'd9) begin
                    n_tens <= 4'd0;
                    n_ones <= 4'd1;
                end else if (n_ones == 4'd9) begin
                    n_tens <= n_tens + 4'd1;
                    n_ones <= 4'd0;
                end else begin
                    n_ones <= n_ones + 4'd1;
                end
            end
        end
    end

    assign n_bin   = 7'(n_tens * 7'd10) + {3'b000, n_ones};
    assign leap7   = {6'b000000, SW[8]};
    assign feb_end = 7'd59 + leap7;
    assign mar_end = 7'd90 + leap7;

    // The month and day are decoded straight from N and the leap switch, so
    // toggling SW[8] moves the calendar digits without touching N.
    always_comb begin
        month = 4'd1;
        day   = n_bin;
        if (n_bin <= 7'd31) begin
            month = 4'd1;
            day   = n_bin;
        end else if (n_bin <= feb_end) begin
            month = 4'd2;
            day   = n_bin - 7'd31;
        end else if (n_bin <= mar_end) begin
            month = 4'd3;
            day   = n_bin - feb_end;
        end else begin
            month = 4'd4;
            day   = n_bin - mar_end;
        end
    end

    // The day of the month never exceeds 31, so three compares yield its tens digit.
    always_comb begin
        day_tens = 4'd0;
        if (day >= 7'd30)      day_tens = 4'd3;
        else if (day >= 7'd20) day_tens = 4'd2;
        else if (day >= 7'd10) day_tens = 4'd1;
        day_ones = 4'(day - 7'(day_tens * 7'd10));
    end

    assign HEX5 = seg7(n_tens);
    assign HEX4 = seg7(n_ones);
    assign HEX3 = 8'hFF;
    assign HEX2 = seg7(month);
    assign HEX1 = seg7(day_tens);
    assign HEX0 = seg7(day_ones);
    assign LEDR = {hb, SW[8]};

endmodule

// File: tb/tb_top_level.sv
`timescale 1ns/1ps
// Scoreboard bench for top_level. The stimulus pushes hand-computed display
// vectors {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0,LEDR}, and the monitor pops each one
// and compares it against the live outputs.
module tb_top_level;

    logic       clk;
    logic [1:0] key;
    logic [9:8] sw;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0] ledr;

    typedef struct {
        string       name;
        logic [49:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_push;
    int   n_pop;
    int   tests;
    int   failed;
    bit   found;

    top_level #(.CLK_DIV(4)) dut (
        .MAX10_CLK1_50(clk),
        .KEY(key),
        .SW(sw),
        .HEX0(hex0),
        .HEX1(hex1),
        .HEX2(hex2),
        .HEX3(hex3),
        .HEX4(hex4),
        .HEX5(hex5),
        .LEDR(ledr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [49:0] ev(input logic [7:0] h5, input logic [7:0] h4,
                                       input logic [7:0] h3, input logic [7:0] h2,
                                       input logic [7:0] h1, input logic [7:0] h0,
                                       input logic [1:0] led);
        return {h5, h4, h3, h2, h1, h0, led};
    endfunction

    task automatic expect_disp(input string name, input logic [49:0] e);
        exp_t item;
        item.name = name;
        item.exp  = e;
        sb_q.push_back(item);
        n_push++;
        #1;
    endtask

    task automatic press_key();
        @(negedge clk);
        key[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        key[1] = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic press_n(input int n);
        for (int i = 0; i < n; i++) press_key();
    endtask

    // Monitor: compare every queued expectation against the outputs.
    initial begin
        exp_t        e;
        logic [49:0] act;
        forever begin
            wait (n_pop != n_push);
            e   = sb_q.pop_front();
            n_pop++;
            act = {hex5, hex4, hex3, hex2, hex1, hex0, ledr};
            tests++;
            if (act !== e.exp) begin
                failed++;
                $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_push = 0;
        n_pop  = 0;
        tests  = 0;
        failed = 0;
        key    = 2'b10;
        sw     = 2'b00;

        // Reset held, with a button press that must be ignored.
        #200 key[1] = 1'b0;
        #200 key[1] = 1'b1;
        #100 expect_disp("in_reset", ev(8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0, 8'hF9, 2'b00));
        #499 key[0] = 1'b1;
        #2000 expect_disp("after_reset", ev(8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0, 8'hF9, 2'b00));

        // First press: latency of three edges, and no repeat while held.
        @(negedge clk);
        key[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 expect_disp("press_edge2", ev(8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0, 8'hF9, 2'b00));
        @(posedge clk);
        #1 expect_disp("press_edge3", ev(8'hC0, 8'hA4, 8'hFF, 8'hF9, 8'hC0, 8'hA4, 2'b00));
        repeat (10) @(posedge clk);
        #1 expect_disp("press_hold", ev(8'hC0, 8'hA4, 8'hFF, 8'hF9, 8'hC0, 8'hA4, 2'b00));
        @(negedge clk);
        key[1] = 1'b1;
        repeat (3) @(posedge clk);

        press_n(30);
        expect_disp("n32_feb1", ev(8'hB0, 8'hA4, 8'hFF, 8'hA4, 8'hC0, 8'hF9, 2'b00));

        press_n(27);
        expect_disp("n59_feb28", ev(8'h92, 8'h90, 8'hFF, 8'hA4, 8'hA4, 8'h80, 2'b00));

        press_n(1);
        expect_disp("n60_nonleap", ev(8'h82, 8'hC0, 8'hFF, 8'hB0, 8'hC0, 8'hF9, 2'b00));
        sw[8] = 1'b1;
        #1 expect_disp("n60_leap", ev(8'h82, 8'hC0, 8'hFF, 8'hA4, 8'hA4, 8'h90, 2'b01));

        press_n(1);
        expect_disp("n61_leap", ev(8'h82, 8'hF9, 8'hFF, 8'hB0, 8'hC0, 8'hF9, 2'b01));
        sw[8] = 1'b0;
        #1 expect_disp("n61_nonleap", ev(8'h82, 8'hF9, 8'hFF, 8'hB0, 8'hC0, 8'hA4, 2'b00));

        press_n(30);
        expect_disp("n91_nonleap", ev(8'h90, 8'hF9, 8'hFF, 8'h99, 8'hC0, 8'hF9, 2'b00));
        sw[8] = 1'b1;
        #1 expect_disp("n91_leap", ev(8'h90, 8'hF9, 8'hFF, 8'hB0, 8'hB0, 8'hF9, 2'b01));
        sw[8] = 1'b0;

        press_n(8);
        expect_disp("n99", ev(8'h90, 8'h90, 8'hFF, 8'h99, 8'hC0, 8'h90, 2'b00));
        press_n(1);
        expect_disp("wrap_01", ev(8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0, 8'hF9, 2'b00));

        // Auto-run: lock onto the first tick, then one step every 4 clocks.
        @(negedge clk);
        sw[9] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (hex4 !== 8'hF9) found = 1'b1;
        end
        if (!found) begin
            tests++;
            failed++;
            $display("FAIL auto_start: got no tick in 8 clocks, required one within 4");
        end
        expect_disp("auto_n02", ev(8'hC0, 8'hA4, 8'hFF, 8'hF9, 8'hC0, 8'hA4, 2'b10));
        repeat (2) @(posedge clk);
        #1 expect_disp("auto_hold", ev(8'hC0, 8'hA4, 8'hFF, 8'hF9, 8'hC0, 8'hA4, 2'b10));
        repeat (2) @(posedge clk);
        #1 expect_disp("auto_n03", ev(8'hC0, 8'hB0, 8'hFF, 8'hF9, 8'hC0, 8'hB0, 2'b00));
        repeat (4) @(posedge clk);
        #1 expect_disp("auto_n04", ev(8'hC0, 8'h99, 8'hFF, 8'hF9, 8'hC0, 8'h99, 2'b10));
        @(negedge clk);
        sw[9] = 1'b0;
        repeat (12) @(posedge clk);
        #1 expect_disp("auto_frozen", ev(8'hC0, 8'h99, 8'hFF, 8'hF9, 8'hC0, 8'h99, 2'b10));

        // Reset mid-operation at N=47 (Feb 16).
        press_n(43);
        expect_disp("n47_feb16", ev(8'h99, 8'hF8, 8'hFF, 8'hA4, 8'hF9, 8'h82, 2'b10));
        @(posedge clk);
        #5 key[0] = 1'b0;
        #1 expect_disp("mid_reset", ev(8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hC0, 8'hF9, 2'b00));
        #20 key[0] = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10 && n_pop != n_push; i++) #1;
        if (n_pop != n_push) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d checked, required %0d", n_pop, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
